// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared constants, types and helpers for the register-file write-port arbiter.
// Optional feature macro: RF_ARB_ZERO_FILTER_EN (drops writes to x0 inside the arbiter).
package rf_pkg;

    localparam int XLEN          = 32;
    localparam int ADDR_W        = 5;
    localparam int REG_COUNT     = 32;
    localparam int N_REQ_DEFAULT = 3;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]   xlen_t;

    // Next round-robin position after index idx in a ring of n entries
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Requester-side bus of the register-file write arbiter: per-requester valid,
// destination address and data, plus the one-hot ready returned by the arbiter.
interface regfile_wr_arbiter_if #(
    parameter int N_REQ  = rf_pkg::N_REQ_DEFAULT,
    parameter int XLEN   = rf_pkg::XLEN,
    parameter int ADDR_W = rf_pkg::ADDR_W
);

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*XLEN-1:0]   req_data;
    logic [N_REQ-1:0]        req_ready;

    // Writeback sources drive requests and observe the grant
    modport master (
        output req_valid,
        output req_addr,
        output req_data,
        input  req_ready
    );

    // The arbiter consumes requests and returns the grant
    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_data,
        output req_ready
    );

endinterface

// File: rtl/regfile_wr_arbiter_rr_pick.sv
// Combinational rotate-priority selector: starting at ptr and wrapping, the
// first valid index wins. Produces a one-hot grant, its index and a found flag.
module rr_pick #(
    parameter  int N_REQ = rf_pkg::N_REQ_DEFAULT,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    import rf_pkg::*;

    // Walk the ring from ptr and latch onto the first valid requester
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            int pos;
            pos = int'(ptr) + k;
            if (pos >= N_REQ) begin
                pos = pos - N_REQ;
            end
            if (!found && valid[pos]) begin
                grant[pos] = 1'b1;
                idx        = IDX_W'(pos);
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the single register-file write port (WE3/A3/WD3)
// between N_REQ writeback sources. A transfer in cycle t becomes a registered
// write command during cycle t+1. wr_stall blocks new grants; wr_flush blocks
// the grant and so forces the next WE3 low (flush dominates stall).
// Optional macro RF_ARB_ZERO_FILTER_EN: transfers to x0 are accepted but never
// turned into a write.
module regfile_wr_arbiter #(
    parameter  int N_REQ  = rf_pkg::N_REQ_DEFAULT,
    parameter  int XLEN   = rf_pkg::XLEN,
    parameter  int ADDR_W = rf_pkg::ADDR_W,
    localparam int IDX_W  = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_wr_arbiter_if.slave  req_if,
    input  logic                 wr_stall,
    input  logic                 wr_flush,
    output logic                 WE3,
    output logic [ADDR_W-1:0]    A3,
    output logic [XLEN-1:0]      WD3,
    output logic [IDX_W-1:0]     grant_id,
    output logic [IDX_W-1:0]     rr_ptr
);

    import rf_pkg::*;

    logic [N_REQ-1:0]  pick_grant;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_found;
    logic              arb_live;
    logic              allow;
    logic              transfer;
    logic              write_ok;
    logic [ADDR_W-1:0] sel_addr;
    logic [XLEN-1:0]   sel_data;
    logic [IDX_W-1:0]  ptr_next;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .valid (req_if.req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Grants are withheld while reset is asserted, during a stall and on a flush
    assign allow            = arb_live && !wr_stall && !wr_flush;
    assign req_if.req_ready = allow ? pick_grant : '0;
    assign transfer         = allow && pick_found;

    assign sel_addr = req_if.req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
    assign sel_data = req_if.req_data[int'(pick_idx)*XLEN +: XLEN];
    assign ptr_next = IDX_W'(wrap_inc(int'(pick_idx), N_REQ));

`ifdef RF_ARB_ZERO_FILTER_EN
    assign write_ok = transfer && (sel_addr != '0);
`else
    assign write_ok = transfer;
`endif

    // Cleared asynchronously by reset so req_ready drops at once; enables grants from the first clock after release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arb_live <= 1'b0;
        end else begin
            arb_live <= 1'b1;
        end
    end

    // Round-robin pointer moves just past the winner on every transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (transfer) begin
            rr_ptr <= ptr_next;
        end
    end

    // Registered write command; address, data and id hold when nothing is written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            WE3      <= 1'b0;
            A3       <= '0;
            WD3      <= '0;
            grant_id <= '0;
        end else begin
            WE3 <= write_ok;
            if (write_ok) begin
                A3       <= sel_addr;
                WD3      <= sel_data;
                grant_id <= pick_idx;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter (N_REQ=3): a reference model
// predicts req_ready and the next write command each cycle, pushes the
// command into a scoreboard queue and compares it after the clock edge.
// Honours RF_ARB_ZERO_FILTER_EN in the model when defined.
module tb_regfile_wr_arbiter;

    localparam int NR = 3;
    localparam int AW = 5;
    localparam int DW = 32;

`ifdef RF_ARB_ZERO_FILTER_EN
    localparam bit ZERO_FILTER = 1'b1;
`else
    localparam bit ZERO_FILTER = 1'b0;
`endif

    typedef struct {
        logic          we;
        logic [AW-1:0] a3;
        logic [DW-1:0] wd3;
        logic [1:0]    gid;
        logic [1:0]    ptr;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       wr_stall;
    logic       wr_flush;
    logic       WE3;
    logic [AW-1:0] A3;
    logic [DW-1:0] WD3;
    logic [1:0] grant_id;
    logic [1:0] rr_ptr;

    int n_checks;
    int n_fail;

    int            m_ptr;
    logic [AW-1:0] m_a3;
    logic [DW-1:0] m_wd3;
    logic [1:0]    m_gid;

    exp_t sb[$];

    regfile_wr_arbiter_if #(.N_REQ(NR), .XLEN(DW), .ADDR_W(AW)) rif ();

    regfile_wr_arbiter #(.N_REQ(NR), .XLEN(DW), .ADDR_W(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_if   (rif.slave),
        .wr_stall (wr_stall),
        .wr_flush (wr_flush),
        .WE3      (WE3),
        .A3       (A3),
        .WD3      (WD3),
        .grant_id (grant_id),
        .rr_ptr   (rr_ptr)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_ptr = 0;
        m_a3  = '0;
        m_wd3 = '0;
        m_gid = '0;
    endtask

    // Drive one cycle of stimulus (called at posedge+1), predict and check
    task automatic applyStimulus(input logic [NR-1:0] valid, input logic [NR*AW-1:0] addrs,
                                 input logic [NR*DW-1:0] datas, input logic stall, input logic flush);
        int            g;
        logic [NR-1:0] exp_ready;
        logic [AW-1:0] a;
        exp_t          e;
        exp_t          got;
        rif.req_valid = valid;
        rif.req_addr  = addrs;
        rif.req_data  = datas;
        wr_stall      = stall;
        wr_flush      = flush;
        #2;
        g = -1;
        if (!stall && !flush) begin
            for (int k = 0; k < NR; k++) begin
                int j;
                j = (m_ptr + k) % NR;
                if (g < 0 && valid[j]) g = j;
            end
        end
        exp_ready = (g >= 0) ? NR'(1 << g) : '0;
        checkOutput("req_ready", 64'(rif.req_ready), 64'(exp_ready));
        e.we = 1'b0;
        if (g >= 0) begin
            m_ptr = (g + 1) % NR;
            a = addrs[g*AW +: AW];
            if (!(ZERO_FILTER && a == '0)) begin
                e.we  = 1'b1;
                m_a3  = a;
                m_wd3 = datas[g*DW +: DW];
                m_gid = 2'(g);
            end
        end
        e.a3  = m_a3;
        e.wd3 = m_wd3;
        e.gid = m_gid;
        e.ptr = 2'(m_ptr);
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        checkOutput("WE3", 64'(WE3), 64'(got.we));
        checkOutput("A3", 64'(A3), 64'(got.a3));
        checkOutput("WD3", 64'(WD3), 64'(got.wd3));
        checkOutput("grant_id", 64'(grant_id), 64'(got.gid));
        checkOutput("rr_ptr", 64'(rr_ptr), 64'(got.ptr));
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_WE3"}, 64'(WE3), 64'd0);
        checkOutput({tag, "_A3"}, 64'(A3), 64'd0);
        checkOutput({tag, "_WD3"}, 64'(WD3), 64'd0);
        checkOutput({tag, "_grant_id"}, 64'(grant_id), 64'd0);
        checkOutput({tag, "_rr_ptr"}, 64'(rr_ptr), 64'd0);
        checkOutput({tag, "_req_ready"}, 64'(rif.req_ready), 64'd0);
    endtask

    // Main stimulus sequence
    initial begin
        logic [NR*AW-1:0] addrs;
        logic [NR*DW-1:0] datas;
        n_checks = 0;
        n_fail   = 0;
        modelReset();
        rst_n         = 1'b0;
        wr_stall      = 1'b0;
        wr_flush      = 1'b0;
        rif.req_valid = 3'b111;
        rif.req_addr  = {5'd3, 5'd2, 5'd1};
        rif.req_data  = {32'h3, 32'h2, 32'h1};
        #3;
        checkResetState("reset_initial");
        repeat (2) @(posedge clk);
        #1;
        checkResetState("reset_clocked");
        rif.req_valid = '0;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] single requester");
        applyStimulus(3'b010, {5'd0, 5'd5, 5'd0}, {32'h0, 32'hDEADBEEF, 32'h0}, 1'b0, 1'b0);
        applyStimulus(3'b100, {5'd9, 5'd0, 5'd0}, {32'h99, 32'h0, 32'h0}, 1'b0, 1'b0);

        $display("[TB] fairness");
        addrs = {5'd12, 5'd11, 5'd10};
        datas = {32'hC0C0_0002, 32'hB0B0_0001, 32'hA0A0_0000};
        for (int i = 0; i < 6; i++) begin
            applyStimulus(3'b111, addrs, datas, 1'b0, 1'b0);
        end

        $display("[TB] stall and flush");
        addrs = {5'd0, 5'd0, 5'd7};
        datas = {32'h0, 32'h0, 32'h7777_0000};
        applyStimulus(3'b001, addrs, datas, 1'b1, 1'b0);
        applyStimulus(3'b001, addrs, datas, 1'b1, 1'b0);
        applyStimulus(3'b001, addrs, datas, 1'b0, 1'b0);
        applyStimulus(3'b011, {5'd0, 5'd8, 5'd7}, {32'h0, 32'h8888, 32'h7777}, 1'b0, 1'b0);
        applyStimulus(3'b111, {5'd4, 5'd8, 5'd7}, {32'h4444, 32'h8888, 32'h7777}, 1'b1, 1'b1);
        applyStimulus(3'b111, {5'd4, 5'd8, 5'd7}, {32'h4444, 32'h8888, 32'h7777}, 1'b0, 1'b1);
        applyStimulus(3'b111, {5'd4, 5'd8, 5'd7}, {32'h4444, 32'h8888, 32'h7777}, 1'b0, 1'b0);

        $display("[TB] zero address");
        applyStimulus(3'b100, {5'd0, 5'd0, 5'd0}, {32'h1234, 32'h0, 32'h0}, 1'b0, 1'b0);
        applyStimulus(3'b000, '0, '0, 1'b0, 1'b0);

        $display("[TB] random traffic");
        for (int i = 0; i < 60; i++) begin
            for (int r = 0; r < NR; r++) begin
                addrs[r*AW +: AW] = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                datas[r*DW +: DW] = $urandom;
            end
            applyStimulus(3'($urandom_range(0, 7)), addrs, datas,
                          $urandom_range(0, 5) == 0, $urandom_range(0, 6) == 0);
        end

        $display("[TB] reset mid-transfer");
        applyStimulus(3'b001, {5'd0, 5'd0, 5'd21}, {32'h0, 32'h0, 32'h2121_2121}, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checkResetState("reset_mid");
        rif.req_valid = '0;
        modelReset();
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(3'b010, {5'd0, 5'd17, 5'd0}, {32'h0, 32'h1717, 32'h0}, 1'b0, 1'b0);
        applyStimulus(3'b000, '0, '0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Shares the single register-file write port (WE3/A3/WD3) between several writeback requesters (ALU, load unit, CSR/debug) with round-robin arbitration and valid/ready handshakes. Sits between the writeback sources and the 32×32 register bank. It drives a registered write command one cycle after acceptance. It supports a stall input from hazard control and a flush of the in-flight command.

## Interface
Parameters:
- N_REQ, 3, number of writeback requesters (2..8)
- XLEN, 32, data width
- ADDR_W, 5, register address width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  N_REQ  requester i has a write pending
- req_addr  in  N_REQ*ADDR_W  destination register, requester i at bits [i*ADDR_W +: ADDR_W]
- req_data  in  N_REQ*XLEN  write data, requester i at bits [i*XLEN +: XLEN]
- req_ready  out  N_REQ  one-hot grant; transfer when req_valid[i] && req_ready[i]
- wr_stall  in  1  hazard control blocks new grants this cycle
- wr_flush  in  1  cancel in-flight command (WE3 forced low next cycle)
- WE3  out  1  register-file write enable (registered)
- A3  out  ADDR_W  write address (registered)
- WD3  out  XLEN  write data (registered)
- grant_id  out  $clog2(N_REQ)  index of requester that produced current WE3 command
- rr_ptr  out  $clog2(N_REQ)  current round-robin pointer (debug)

## Operation
- req_ready is combinational from req_valid, rr_ptr, wr_stall. It is never a function of req_ready.
- At most one bit of req_ready is high. It is zero when wr_stall=1 or no valid requests.
- Arbitration: search indices rr_ptr, rr_ptr+1, … mod N_REQ; the first valid index wins.
- On a transfer by requester g: rr_ptr ← (g+1) mod N_REQ.
- With no transfer, rr_ptr holds.
- On a transfer, the output register loads WE3=1, A3=req_addr[g], WD3=req_data[g], grant_id=g.
- With no transfer, the output register loads WE3=0. A3, WD3 and grant_id hold their last values.
- The output stage drains every cycle because the bank always accepts. Throughput is one write per cycle, with no backpressure beyond wr_stall.
- wr_flush=1 forces the next WE3=0 and suppresses that cycle's transfer: req_ready=0 and rr_ptr holds. Flush dominates stall.
- Requester i must hold req_addr, req_data and valid until the transfer. Dropping valid early is legal, and the requester then loses its turn.
- Same-address requests in the same cycle: only the granted one is written. Others wait. There is no merging.

## Timing
- Reset (rst_n=0, async): WE3=0, A3=0, WD3=0, grant_id=0, rr_ptr=0. req_ready=0 while reset is asserted.
- Reset mid-operation clears the in-flight command. The pending write is lost, and requesters retry after reset.
- Latency: transfer in cycle t → WE3=1 throughout cycle t+1 → bank written at the rising edge ending t+1.
- Back-to-back transfers give WE3 high on consecutive cycles.
- wr_stall sampled high in cycle t: no transfer in t. The command already in flight from t-1 still completes.
- rr_ptr wrap: after a grant to N_REQ-1, the pointer returns to 0.

## Configuration
- RF_ARB_ZERO_FILTER_EN:
  - Defined: a transfer with req_addr=0 is accepted (req_ready, rr_ptr update) but produces WE3=0, and A3/WD3 hold. x0 is never written.
  - Undefined: writes to address 0 pass through like any other, and x0 protection is the bank's responsibility.

## Structure
- Package rf_pkg holds:
  - XLEN, ADDR_W, REG_COUNT=32
  - typedef reg_addr_t (ADDR_W bits)
  - typedef xlen_t (XLEN bits)
  - default N_REQ
- Sub-module rr_pick: combinational N_REQ-wide rotate-priority selector with inputs valid and ptr, and outputs one-hot grant plus index. The top level holds the pointer and output registers.

## Test plan
- Reset: rst_n low mid-transfer with WE3=1 → WE3=0, rr_ptr=0 immediately, without waiting for a clock edge.
- Single requester: req 1 valid, addr=5, data=0xDEADBEEF at t → WE3=1, A3=5, WD3=0xDEADBEEF, grant_id=1 at t+1; rr_ptr=2.
- Fairness: all 3 valid for 6 cycles from rr_ptr=0 → grant order 0,1,2,0,1,2; WE3 high for 6 consecutive cycles.
- Stall and flush:
  - wr_stall=1 for 2 cycles with req 0 valid → req_ready=0, WE3=0 in the following cycles, rr_ptr unchanged.
  - Grant then resumes the cycle after stall drops.
  - wr_flush=1 with stall=1 → WE3=0 next cycle.
- Zero filter: req 2 writes addr=0, data=0x1234. With RF_ARB_ZERO_FILTER_EN defined → req_ready[2]=1, WE3=0 next cycle, rr_ptr=0. Without it → WE3=1, A3=0.
